pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
Central hazard and stall controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB). It drives the load and flush/reset inputs of every inter-stage register and the PC. It arbitrates memory-wait stalls, load-use bubbles, multi-cycle EX operations and branch-mispredict flushes. It also tracks early I-fetch responses so that no fetched instruction is lost while the D-side is still waiting.

Parameters:
STALL_TIMEOUT, 1024, consecutive frozen cycles before stall_timeout sets (>=2)
CNT_WIDTH, 32, width of the watchdog and performance counters

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous reset, active-low
imem_read  in  1  I-side request active
imem_resp  in  1  I-side response, one-cycle pulse
dmem_read  in  1  D-side load request active (MEM stage)
dmem_write  in  1  D-side store request active (MEM stage)
dmem_resp  in  1  D-side response, one-cycle pulse
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX-stage destination register
ex_is_load  in  1  EX-stage instruction is a load
ex_busy  in  1  multi-cycle EX unit is still computing
ex_mispredict  in  1  EX resolved a branch/jump as redirected
load_pc  out  1  PC register load
load_if_id  out  1  IF/ID load
load_id_ex  out  1  ID/EX load
load_ex_mem  out  1  EX/MEM load
load_mem_wb  out  1  MEM/WB load
flush_if_id  out  1  IF/ID synchronous clear
flush_id_ex  out  1  ID/EX synchronous clear
flush_ex_mem  out  1  EX/MEM synchronous clear
ifbuf_load  out  1  capture the I-fetch data into the fetch holding buffer
ifbuf_sel  out  1  IF/ID input comes from the fetch holding buffer
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (reset_n=0 at clk edge):
  - All load_* = 0, all flush_* = 1, ifbuf_* = 0.
  - State = RUN, ifetch_done = 0, dfetch_done = 0.
  - Watchdog counter = 0, stall_timeout = 0.
  - While reset_n=0 the outputs are forced to these values combinationally.
- Outputs are combinational from the inputs plus registered state. There is no added latency: a stall blocks the same-edge register update.
- Derived terms:
  - istall = imem_read & ~imem_resp & ~ifetch_done
  - dstall = (dmem_read|dmem_write) & ~dmem_resp & ~dfetch_done
  - freeze = istall | dstall
  - lu_hazard = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Priority, highest first:
  1. freeze: all load_* = 0, all flush_* = 0.
  2. ex_busy: load_pc, load_if_id, load_id_ex = 0. load_ex_mem = 1 with flush_ex_mem = 1 (bubble into MEM). load_mem_wb = 1.
  3. ex_mispredict: all loads 1, flush_if_id = 1, flush_id_ex = 1. Mispredict overrides lu_hazard.
  4. lu_hazard: load_pc = 0, load_if_id = 0, load_id_ex = 1 with flush_id_ex = 1, load_ex_mem = 1, load_mem_wb = 1.
  5. Otherwise all loads 1, all flushes 0.
- FSM:
  - RUN -> WAIT when freeze=1.
  - WAIT -> RUN in the first cycle freeze=0. The pipeline advances in that same cycle.
  - WAIT -> WAIT otherwise.
- Early-response tracking:
  - imem_resp while dstall=1 in RUN or WAIT: ifbuf_load = 1 and ifetch_done <= 1.
  - dmem_resp while istall=1: dfetch_done <= 1. MEM/WB data is held by the MEM-stage register.
  - ifbuf_sel = ifetch_done.
  - Both done flags clear on the edge where load_pc=1, or when ex_mispredict advances.
  - A response arriving in the same cycle freeze falls is consumed directly: no buffer use, flag stays 0.
- Watchdog:
  - Counter increments each cycle freeze|ex_busy=1 and clears otherwise.
  - Reaching STALL_TIMEOUT sets stall_timeout. It stays set until reset. The counter saturates.
- A reset asserted mid-stall abandons all pending flags, and the next cycle behaves as post-reset.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cycles, perf_bubbles and perf_flushes, each CNT_WIDTH bits, saturating, reset to 0:
  - perf_stall_cycles increments on freeze.
  - perf_bubbles increments on lu_hazard or ex_busy when not frozen.
  - perf_flushes increments on an accepted ex_mispredict.
- When undefined, these ports and registers do not exist and the rest of the behaviour is identical.

Test Plan:
- Hold reset_n=0 for 2 cycles -> all load_*=0, flush_*=1, stall_timeout=0. First cycle after release with no hazards -> all loads 1, flushes 0.
- EX lw x5, ID add x6,x5,x1 (uses rs1=5) -> one cycle load_pc=0, load_if_id=0, flush_id_ex=1. Next cycle, ex_is_load on the bubble is 0 -> normal advance.
- dmem_read=1 for 4 cycles, dmem_resp on 4th -> loads 0 for 3 cycles, all 1 on 4th. FSM RUN->WAIT->RUN.
- imem_resp in cycle 1, dmem_resp in cycle 3 -> ifbuf_load=1 in cycle 1; ifbuf_sel=1 in cycles 2-3; ifetch_done clears after the cycle-3 advance.
- ex_mispredict=1 together with lu_hazard=1 -> flush_if_id=1, flush_id_ex=1, load_pc=1. With dstall=1 as well -> all outputs 0 until the response arrives.
- STALL_TIMEOUT=8, dmem stalled for 10 cycles -> stall_timeout rises after the 8th frozen cycle and stays 1 after the response.

Source files
------------

// File: rtl/pipeline_control.sv
// Hazard/stall controller for the 5-stage RV32I pipeline: drives register loads/flushes,
// holds early fetch responses and runs a stall watchdog. Optional perf counters: PIPE_PERF_CNT_EN.
module pipeline_control #(
  parameter int unsigned STALL_TIMEOUT = 1024,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       imem_read,
  input  logic       imem_resp,
  input  logic       dmem_read,
  input  logic       dmem_write,
  input  logic       dmem_resp,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_is_load,
  input  logic       ex_busy,
  input  logic       ex_mispredict,
  output logic       load_pc,
  output logic       load_if_id,
  output logic       load_id_ex,
  output logic       load_ex_mem,
  output logic       load_mem_wb,
  output logic       flush_if_id,
  output logic       flush_id_ex,
  output logic       flush_ex_mem,
  output logic       ifbuf_load,
  output logic       ifbuf_sel,
  output logic       stall_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_cycles,
  output logic [CNT_WIDTH-1:0] perf_bubbles,
  output logic [CNT_WIDTH-1:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(STALL_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 ifetch_done_q, ifetch_done_d;
  logic                 dfetch_done_q, dfetch_done_d;
  logic [CNT_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                 timeout_q, timeout_d;

  logic istall, dstall, freeze, lu_hazard, mispredict_adv;

  always_comb begin
    istall    = imem_read & ~imem_resp & ~ifetch_done_q;
    dstall    = (dmem_read | dmem_write) & ~dmem_resp & ~dfetch_done_q;
    freeze    = istall | dstall;
    lu_hazard = ex_is_load && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));
    mispredict_adv = ex_mispredict & ~freeze & ~ex_busy;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  // FSM: next state; WAIT releases in the first unfrozen cycle, which also advances
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (freeze)  state_d = ST_WAIT;
      ST_WAIT: if (!freeze) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs, in hazard priority order
  always_comb begin
    load_pc       = 1'b1;
    load_if_id    = 1'b1;
    load_id_ex    = 1'b1;
    load_ex_mem   = 1'b1;
    load_mem_wb   = 1'b1;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    flush_ex_mem  = 1'b0;
    ifbuf_load    = 1'b0;
    ifbuf_sel     = ifetch_done_q;
    stall_timeout = timeout_q;
    if (!reset_n) begin
      {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b00000;
      {flush_if_id, flush_id_ex, flush_ex_mem} = 3'b111;
      ifbuf_sel     = 1'b0;
      stall_timeout = 1'b0;
    end else begin
      if (freeze) begin
        {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = 5'b00000;
      end else if (ex_busy) begin
        {load_pc, load_if_id, load_id_ex} = 3'b000;
        flush_ex_mem = 1'b1;
      end else if (ex_mispredict) begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (lu_hazard) begin
        {load_pc, load_if_id} = 2'b00;
        flush_id_ex = 1'b1;
      end
      // An I-response during a D-side stall would be lost without the holding buffer
      case (state_q)
        ST_RUN, ST_WAIT: ifbuf_load = imem_resp & dstall;
        default:         ifbuf_load = 1'b0;
      endcase
    end
  end

  always_comb begin
    ifetch_done_d = ifetch_done_q;
    dfetch_done_d = dfetch_done_q;
    if (load_pc || mispredict_adv) begin
      ifetch_done_d = 1'b0;
      dfetch_done_d = 1'b0;
    end else begin
      if (ifbuf_load)          ifetch_done_d = 1'b1;
      if (dmem_resp && istall) dfetch_done_d = 1'b1;
    end
  end

  always_comb begin
    wd_cnt_d = '0;
    if (freeze || ex_busy) wd_cnt_d = (wd_cnt_q >= TIMEOUT) ? wd_cnt_q : wd_cnt_q + CNT_ONE;
    timeout_d = timeout_q | (wd_cnt_d >= TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ifetch_done_q <= 1'b0;
      dfetch_done_q <= 1'b0;
      wd_cnt_q      <= '0;
      timeout_q     <= 1'b0;
    end else begin
      ifetch_done_q <= ifetch_done_d;
      dfetch_done_q <= dfetch_done_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_q     <= timeout_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] perf_stall_q, perf_stall_d;
  logic [CNT_WIDTH-1:0] perf_bubble_q, perf_bubble_d;
  logic [CNT_WIDTH-1:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_bubble_d = perf_bubble_q;
    perf_flush_d  = perf_flush_q;
    if (freeze && perf_stall_q != CNT_MAX)
      perf_stall_d = perf_stall_q + CNT_ONE;
    if (!freeze && (lu_hazard || ex_busy) && perf_bubble_q != CNT_MAX)
      perf_bubble_d = perf_bubble_q + CNT_ONE;
    if (mispredict_adv && perf_flush_q != CNT_MAX)
      perf_flush_d = perf_flush_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_stall_q  <= '0;
      perf_bubble_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_bubbles      = perf_bubble_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control (STALL_TIMEOUT=8).
module tb_pipeline_control;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_is_load, ex_busy, ex_mispredict;
  logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem;
  logic       ifbuf_load, ifbuf_sel, stall_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_bubbles, perf_flushes;
`endif

  int checks = 0;
  int fails  = 0;

  pipeline_control #(.STALL_TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_busy(ex_busy), .ex_mispredict(ex_mispredict),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .ifbuf_load(ifbuf_load), .ifbuf_sel(ifbuf_sel), .stall_timeout(stall_timeout)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_bubbles(perf_bubbles),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  // {loads[4:0], flushes[2:0], ifbuf_load, ifbuf_sel}
  wire [9:0] obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    flush_if_id, flush_id_ex, flush_ex_mem, ifbuf_load, ifbuf_sel};

  localparam logic [9:0] O_RESET = 10'b00000_111_00;
  localparam logic [9:0] O_RUN   = 10'b11111_000_00;
  localparam logic [9:0] O_FRZ   = 10'b00000_000_00;
  localparam logic [9:0] O_LU    = 10'b00111_010_00;
  localparam logic [9:0] O_BUSY  = 10'b00011_001_00;
  localparam logic [9:0] O_MISP  = 10'b11111_110_00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_read = 0; imem_resp = 0; dmem_read = 0; dmem_write = 0; dmem_resp = 0;
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd = 0; ex_is_load = 0; ex_busy = 0; ex_mispredict = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; idle();
    step(); step();
    #1;
    checks++;
    if (obs !== O_RESET) begin fails++; $display("FAIL reset_outputs got=%b exp=%b", obs, O_RESET); end
    checks++;
    if (stall_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout); end
    // outputs stay forced regardless of hazard inputs
    ex_mispredict = 1; dmem_read = 1; #1;
    checks++;
    if (obs !== O_RESET) begin fails++; $display("FAIL reset_forced got=%b exp=%b", obs, O_RESET); end
    step();
    idle(); reset_n = 1; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL post_reset_run got=%b exp=%b", obs, O_RUN); end
    step();
  endtask

  task automatic test_load_use();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1; id_rs2 = 1; id_uses_rs2 = 1; #1;
    checks++;
    if (obs !== O_LU) begin fails++; $display("FAIL lu_rs1 got=%b exp=%b", obs, O_LU); end
    step();
    ex_is_load = 0; ex_rd = 0; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL lu_bubble_adv got=%b exp=%b", obs, O_RUN); end
    // rd=x0 never hazards
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL lu_x0 got=%b exp=%b", obs, O_RUN); end
    // matching rs1 that is not read
    ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 0; id_rs2 = 3; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL lu_unused_rs1 got=%b exp=%b", obs, O_RUN); end
    id_rs2 = 7; #1;
    checks++;
    if (obs !== O_LU) begin fails++; $display("FAIL lu_rs2 got=%b exp=%b", obs, O_LU); end
    step(); idle(); step();
  endtask

  task automatic test_dstall();
    dmem_read = 1;
    for (int c = 1; c <= 4; c++) begin
      dmem_resp = (c == 4); #1;
      checks++;
      if (obs !== ((c == 4) ? O_RUN : O_FRZ)) begin
        fails++; $display("FAIL dstall_c%0d got=%b exp=%b", c, obs, (c == 4) ? O_RUN : O_FRZ);
      end
      step();
    end
    idle(); dmem_write = 1; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL store_stall got=%b exp=%b", obs, O_FRZ); end
    dmem_resp = 1; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL store_resp got=%b exp=%b", obs, O_RUN); end
    step(); idle(); step();
  endtask

  task automatic test_early_ifetch();
    imem_read = 1; imem_resp = 1; dmem_read = 1; #1;
    checks++;
    if (obs !== 10'b00000_000_10) begin fails++; $display("FAIL if_c1 got=%b exp=%b", obs, 10'b00000_000_10); end
    step();
    imem_resp = 0; #1;
    checks++;
    if (obs !== 10'b00000_000_01) begin fails++; $display("FAIL if_c2 got=%b exp=%b", obs, 10'b00000_000_01); end
    step();
    dmem_resp = 1; #1;
    checks++;
    if (obs !== 10'b11111_000_01) begin fails++; $display("FAIL if_c3 got=%b exp=%b", obs, 10'b11111_000_01); end
    step();
    // flag cleared: a fresh un-answered fetch stalls again
    dmem_read = 0; dmem_resp = 0; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL if_c4_clear got=%b exp=%b", obs, O_FRZ); end
    step();
    imem_resp = 1; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL if_direct got=%b exp=%b", obs, O_RUN); end
    step(); idle(); step();
  endtask

  task automatic test_early_dfetch();
    imem_read = 1; dmem_read = 1; dmem_resp = 1; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL df_c1 got=%b exp=%b", obs, O_FRZ); end
    step();
    dmem_resp = 0; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL df_c2 got=%b exp=%b", obs, O_FRZ); end
    imem_resp = 1; #1;
    checks++;
    if (obs !== O_RUN) begin fails++; $display("FAIL df_c2_adv got=%b exp=%b", obs, O_RUN); end
    step();
    imem_read = 0; imem_resp = 0; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL df_clear got=%b exp=%b", obs, O_FRZ); end
    step(); idle(); step();
  endtask

  task automatic test_mispredict();
    ex_mispredict = 1; ex_is_load = 1; ex_rd = 9; id_rs1 = 9; id_uses_rs1 = 1; #1;
    checks++;
    if (obs !== O_MISP) begin fails++; $display("FAIL misp_over_lu got=%b exp=%b", obs, O_MISP); end
    dmem_read = 1; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL misp_frozen got=%b exp=%b", obs, O_FRZ); end
    step(); #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL misp_frozen2 got=%b exp=%b", obs, O_FRZ); end
    dmem_resp = 1; #1;
    checks++;
    if (obs !== O_MISP) begin fails++; $display("FAIL misp_release got=%b exp=%b", obs, O_MISP); end
    step(); idle();
    ex_busy = 1; ex_mispredict = 1; #1;
    checks++;
    if (obs !== O_BUSY) begin fails++; $display("FAIL busy_over_misp got=%b exp=%b", obs, O_BUSY); end
    step(); idle(); step();
  endtask

  task automatic test_timeout();
    dmem_read = 1;
    for (int c = 1; c <= 10; c++) begin
      #1;
      checks++;
      if (stall_timeout !== (c >= 9)) begin
        fails++; $display("FAIL timeout_c%0d got=%b exp=%b", c, stall_timeout, c >= 9);
      end
      step();
    end
    dmem_resp = 1; step(); idle(); step(); #1;
    checks++;
    if (stall_timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", stall_timeout); end
    reset_n = 0; step(); reset_n = 1; #1;
    checks++;
    if (stall_timeout !== 1'b0) begin fails++; $display("FAIL timeout_reset got=%b exp=0", stall_timeout); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    imem_read = 1; imem_resp = 1; dmem_read = 1; step();
    imem_resp = 0; #1;
    checks++;
    if (ifbuf_sel !== 1'b1) begin fails++; $display("FAIL mid_sel_set got=%b exp=1", ifbuf_sel); end
    reset_n = 0; #1;
    checks++;
    if (obs !== O_RESET) begin fails++; $display("FAIL mid_reset got=%b exp=%b", obs, O_RESET); end
    step();
    reset_n = 1; dmem_read = 0; #1;
    checks++;
    if (obs !== O_FRZ) begin fails++; $display("FAIL mid_flag_dropped got=%b exp=%b", obs, O_FRZ); end
    step(); idle(); step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dstall();
    test_early_ifetch();
    test_early_dfetch();
    test_mispredict();
    test_timeout();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
